fetch_unit: RTL and testbench

- Instruction-fetch sequencer: the producing end of the instruction-register load interface.
- Owns the program counter and runs the memory read handshake.
- Holds the returned word stable, then pulses the 2-bit IR load code (2'b10) for exactly one cycle so the IR captures the word.
- Sits between the control FSM (fetch requests, branch PC loads) and the memory port.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 13 +
 rtl/pc_counter.sv | 44 ++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IR load codes, fetch sequencer states and default widths.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] REC_NONE    = 2'b00;
    localparam logic [1:0] REC_LOAD_IR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W_DEF,
    parameter int DATA_W = cpu_pkg::DATA_W_DEF
);
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output rd, output addr, input ready, input rdata);
    modport slave  (input rd, input addr, output ready, output rdata);
endinterface

// File: rtl/pc_counter.sv
// Program counter with direct load, post-fetch increment (wrapping) and a pending branch slot.
module pc_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_direct,
    input  logic              load_defer,
    input  logic              advance,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] pc
);

    logic              pending;
    logic [ADDR_W-1:0] pending_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            pending    <= 1'b0;
            pending_pc <= '0;
        end else if (advance) begin
            // A branch arriving on the completion edge itself is the newest target.
            pending <= 1'b0;
            if (load_defer)
                pc <= pc_in;
            else if (pending)
                pc <= pending_pc;
            else
                pc <= base + ADDR_W'(1);
        end else if (load_direct) begin
            // A direct load supersedes any branch still parked from an abandoned fetch.
            pc      <= pc_in;
            pending <= 1'b0;
        end else if (load_defer) begin
            pending_pc <= pc_in;
            pending    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: runs the memory read handshake and pulses the IR load code.
// Optional read timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    fetch_unit_if.master      mem,
    output logic [DATA_W-1:0] ir_data,
    output logic [1:0]        rec,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT must be at least 1");
    end

    fetch_state_t      state, state_nxt;
    logic              launch;
    logic              capture;
    logic [ADDR_W-1:0] fetch_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: if (fetch_req) begin
                launch    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (mem.ready) begin
                capture   = 1'b1;
                state_nxt = LOAD;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                // This stall cycle brings the count to TIMEOUT: abandon the read.
                timeout_hit = 1'b1;
                state_nxt   = IDLE;
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            fault <= timeout_hit;
            if (launch)
                wait_cnt <= '0;
            else if (state == WAIT && !mem.ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: if (fetch_req) begin
                launch    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (mem.ready) begin
                capture   = 1'b1;
                state_nxt = LOAD;
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fault = 1'b0;
`endif

    // Same-cycle branch and fetch read from the branch target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr <= '0;
            ir_data    <= '0;
        end else begin
            if (launch)
                fetch_addr <= pc_load ? pc_in : pc;
            if (capture)
                ir_data <= mem.rdata;
        end
    end

    pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk         (clk),
        .reset       (reset),
        .load_direct (pc_load && (state == IDLE || state == LOAD)),
        .load_defer  (pc_load && (state == WAIT)),
        .advance     (capture),
        .pc_in       (pc_in),
        .base        (fetch_addr),
        .pc          (pc)
    );

    assign mem.rd   = (state == WAIT);
    assign mem.addr = fetch_addr;
    assign rec      = (state == LOAD) ? REC_LOAD_IR : REC_NONE;
    assign done     = (state == LOAD);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetch transactions.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ir_data;
    logic [1:0]  rec;
    logic [15:0] pc;
    logic        busy, done, fault;

    int n_total = 0;
    int n_pass  = 0;
    logic [15:0] model_pc = '0;

    fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) mem ();
    assign mem.ready = mem_ready;
    assign mem.rdata = mem_rdata;

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_req (fetch_req),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .mem       (mem),
        .ir_data   (ir_data),
        .rec       (rec),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"}, mem.rd, 0);
        check_eq({tag, "_addr"}, mem.addr, 0);
        check_eq({tag, "_ir"}, ir_data, 0);
        check_eq({tag, "_rec"}, rec, REC_NONE);
        check_eq({tag, "_pc"}, pc, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_fault"}, fault, 0);
    endtask

    task automatic idle_load(input logic [15:0] v);
        pc_load = 1'b1;
        pc_in   = v;
        @(negedge clk);
        pc_load  = 1'b0;
        model_pc = v;
        check_eq("idle_load_pc", pc, model_pc);
    endtask

    // One fetch from an IDLE negedge back to the following IDLE negedge.
    task automatic fetch_txn(input bit same_load, input logic [15:0] tgt, input int stall,
                             input bit wait_load, input int wl_cyc, input logic [15:0] wtgt,
                             input bit load_load, input logic [15:0] ltgt,
                             input logic [15:0] word, input bit extra);
        logic [15:0] exp_addr;
        logic [15:0] exp_pc;
        exp_addr = same_load ? tgt : model_pc;
        exp_pc   = wait_load ? wtgt : exp_addr + 16'd1;

        fetch_req = 1'b1;
        pc_load   = same_load;
        pc_in     = tgt;
        @(negedge clk);
        fetch_req = extra;
        for (int i = 0; i <= stall; i++) begin
            check_eq("wait_rd", mem.rd, 1);
            check_eq("wait_addr", mem.addr, exp_addr);
            check_eq("wait_rec", rec, REC_NONE);
            check_eq("wait_pc", pc, exp_addr);
            pc_load   = wait_load && (i == wl_cyc);
            pc_in     = wtgt;
            mem_ready = (i == stall);
            mem_rdata = (i == stall) ? word : 16'($urandom);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        pc_load   = load_load;
        pc_in     = ltgt;
        check_eq("load_rec", rec, REC_LOAD_IR);
        check_eq("load_done", done, 1);
        check_eq("load_ir", ir_data, word);
        check_eq("load_rd", mem.rd, 0);
        check_eq("load_pc", pc, exp_pc);
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        if (load_load)
            exp_pc = ltgt;
        check_eq("idle_rec", rec, REC_NONE);
        check_eq("idle_done", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_pc", pc, exp_pc);
        check_eq("idle_ir", ir_data, word);
        check_eq("idle_fault", fault, 0);
        model_pc = exp_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        fetch_txn(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hA5C3, 0);
        check_eq("first_pc", pc, 16'h0001);
        fetch_txn(0, 16'h0000, 4, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 0);
        fetch_txn(1, 16'h0040, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0BEE, 0);
        check_eq("same_cycle_pc", pc, 16'h0041);
        idle_load(16'h0005);
        fetch_txn(0, 16'h0000, 2, 1, 1, 16'h0100, 0, 16'h0000, 16'h5A5A, 1);
        check_eq("wait_branch_pc", pc, 16'h0100);
        idle_load(16'h0007);
        fetch_txn(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0200, 16'hC0DE, 0);
        check_eq("load_branch_pc", pc, 16'h0200);
        idle_load(16'hFFFF);
        fetch_txn(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h7777, 0);
        check_eq("wrap_pc", pc, 16'h0000);

        // Reset asserted while the read is outstanding.
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_rd", mem.rd, 1);
        #1 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        check_eq("reset_no_rec", rec, REC_NONE);
        reset = 1'b0;
        model_pc = '0;
        @(negedge clk);

`ifdef FETCH_TIMEOUT_EN
        idle_load(16'h0033);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check_eq("to_rd", mem.rd, 1);
            check_eq("to_fault_early", fault, 0);
            @(negedge clk);
        end
        check_eq("to_fault", fault, 1);
        check_eq("to_rd_drop", mem.rd, 0);
        check_eq("to_busy", busy, 0);
        check_eq("to_pc", pc, 16'h0033);
        check_eq("to_rec", rec, REC_NONE);
        @(negedge clk);
        check_eq("to_fault_pulse", fault, 0);
`else
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check_eq("nofault_rd", mem.rd, 1);
            check_eq("nofault_fault", fault, 0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h4321;
        @(negedge clk);
        mem_ready = 1'b0;
        check_eq("nofault_rec", rec, REC_LOAD_IR);
        @(negedge clk);
        model_pc = 16'h0001;
        check_eq("nofault_pc", pc, model_pc);
`endif

        for (int t = 0; t < 40; t++) begin
            int st;
            int wl;
            st = int'($urandom_range(0, 5));
            wl = int'($urandom_range(0, st));
            if ($urandom_range(0, 3) == 0)
                idle_load(16'($urandom));
            fetch_txn(1'($urandom), 16'($urandom), st, 1'($urandom), wl, 16'($urandom),
                      ($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
